// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR burst-averaging sequencer:
//   - default NBIT / LOG2_AVG / TIMEOUT values
//   - sequencer state encoding
//   - result record {data, err, warn} at the default code width
// -----------------------------------------------------------------------------
package sar_pkg;

   localparam int SAR_NBIT     = 10;
   localparam int SAR_LOG2_AVG = 2;
   localparam int SAR_TIMEOUT  = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SOC  = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } sar_state_e;

   typedef struct packed {
      logic [SAR_NBIT-1:0] data;
      logic                err;
      logic                warn;
   } sar_res_t;

endpackage

// File: rtl/sar_watchdog.sv
// -----------------------------------------------------------------------------
// sar_watchdog
// Saturating cycle counter guarding one SAR conversion.
//   f100m_clk  in   system clock
//   rstb       in   asynchronous active-low reset
//   i_clr      in   synchronous clear (takes priority over i_en)
//   i_en       in   count enable, one count per enabled cycle
//   o_tc       out  high while enabled and the count sits at TIMEOUT-1
// -----------------------------------------------------------------------------
module sar_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic f100m_clk,
   input  logic rstb,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int            WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] TC = WW'(TIMEOUT - 1);

   logic [WW-1:0] r_cnt;

   always_ff @(posedge f100m_clk or negedge rstb) begin
      if (!rstb) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != TC)) begin
         r_cnt <= r_cnt + WW'(1);
      end
   end

   // Gated with the enable so the terminal count only means something while
   // a conversion is actually outstanding.
   assign o_tc = i_en && (r_cnt == TC);

endmodule

// File: rtl/sar_burst_avg.sv
// -----------------------------------------------------------------------------
// sar_burst_avg
// Conversion sequencer above the resynchronised SAR handshake. Issues soc
// pulses, accumulates 2^LOG2_AVG codes, and presents the truncated average
// with sticky err/warn status on a valid/ready interface. A watchdog aborts
// a burst whose eoc does not arrive within TIMEOUT cycles of soc.
//   f100m_clk  in   system clock
//   rstb       in   asynchronous active-low reset
//   start      in   one-cycle single-burst request (ignored while busy)
//   cont       in   continuous burst mode while high
//   soc        out  one-cycle start-of-conversion pulse
//   eoc        in   one-cycle end-of-conversion pulse (resynchronised)
//   err        in   one-cycle SAR error pulse (resynchronised)
//   warn       in   one-cycle SAR warning pulse (resynchronised)
//   code       in   SAR result, stable while eoc is high
//   res_data   out  averaged result
//   res_err    out  an err pulse was seen during the burst
//   res_warn   out  a warn pulse was seen during the burst
//   res_valid  out  result available
//   res_ready  in   consumer accepts the result
//   busy       out  sequencer not idle
//   timeout    out  one-cycle pulse when a burst is aborted
// LOG2_AVG is meaningful over 0..6; TIMEOUT must be at least 2.
// -----------------------------------------------------------------------------
module sar_burst_avg
   import sar_pkg::*;
#(
   parameter int NBIT     = SAR_NBIT,
   parameter int LOG2_AVG = SAR_LOG2_AVG,
   parameter int TIMEOUT  = SAR_TIMEOUT
) (
   input  logic            f100m_clk,
   input  logic            rstb,
   input  logic            start,
   input  logic            cont,
   output logic            soc,
   input  logic            eoc,
   input  logic            err,
   input  logic            warn,
   input  logic [NBIT-1:0] code,
   output logic [NBIT-1:0] res_data,
   output logic            res_err,
   output logic            res_warn,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            busy,
   output logic            timeout
);

   // Accumulator is wide enough for 2^LOG2_AVG full-scale codes.
   localparam int AW = NBIT + LOG2_AVG;
   // Keep the sample counter at least one bit wide for LOG2_AVG = 0.
   localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam logic [CW-1:0] LAST = CW'((1 << LOG2_AVG) - 1);

   // Result record at this instance's code width.
   typedef struct packed {
      logic [NBIT-1:0] data;
      logic            err;
      logic            warn;
   } res_t;

   sar_state_e      r_state;
   logic [AW-1:0]   r_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_err_s;
   logic            r_warn_s;
   res_t            r_res;
   logic            r_res_valid;

   logic [AW-1:0]   w_sum;
   logic [NBIT-1:0] w_avg;
   logic            w_last;
   logic            w_wd_tc;
   logic            w_wd_clr;
   logic            w_wd_en;
   logic            w_abort;

   assign w_sum  = r_acc + AW'(code);
   // Divide by 2^LOG2_AVG by dropping the low bits (truncation).
   assign w_avg  = w_sum[AW-1:LOG2_AVG];
   assign w_last = (r_cnt == LAST);

   // Watchdog restarts on every soc and only runs while a conversion is
   // outstanding.
   assign w_wd_clr = (r_state == ST_SOC);
   assign w_wd_en  = (r_state == ST_WAIT);

   sar_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .f100m_clk (f100m_clk),
      .rstb      (rstb),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_tc      (w_wd_tc)
   );

   // An eoc in the expiry cycle rescues the conversion, so the abort has to
   // see the live eoc rather than a registered copy.
   assign w_abort = w_wd_tc && !eoc;

   always_ff @(posedge f100m_clk or negedge rstb) begin
      if (!rstb) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_err_s     <= 1'b0;
         r_warn_s    <= 1'b0;
         r_res       <= '0;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start || cont) r_state <= ST_SOC;
            end

            ST_SOC: begin
               r_err_s  <= r_err_s  | err;
               r_warn_s <= r_warn_s | warn;
               r_state  <= ST_WAIT;
            end

            ST_WAIT: begin
               if (eoc) begin
                  r_acc <= w_sum;
                  if (w_last) begin
                     // Flags pulsing alongside the final eoc belong to this result.
                     r_res.data  <= w_avg;
                     r_res.err   <= r_err_s  | err;
                     r_res.warn  <= r_warn_s | warn;
                     r_res_valid <= 1'b1;
                     r_state     <= ST_OUT;
                  end else begin
                     r_cnt    <= r_cnt + CW'(1);
                     r_err_s  <= r_err_s  | err;
                     r_warn_s <= r_warn_s | warn;
                     r_state  <= ST_SOC;
                  end
               end else if (w_abort) begin
                  // Abort drops the partial burst, even in continuous mode.
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_err_s  <= 1'b0;
                  r_warn_s <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_err_s  <= r_err_s  | err;
                  r_warn_s <= r_warn_s | warn;
               end
            end

            ST_OUT: begin
               // Result held until taken; no soc is issued meanwhile.
               if (res_ready) begin
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_err_s     <= 1'b0;
                  r_warn_s    <= 1'b0;
                  r_res_valid <= 1'b0;
                  r_state     <= cont ? ST_SOC : ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign soc       = (r_state == ST_SOC);
   assign busy      = (r_state != ST_IDLE);
   assign timeout   = (r_state == ST_WAIT) && w_abort;
   assign res_data  = r_res.data;
   assign res_err   = r_res.err;
   assign res_warn  = r_res.warn;
   assign res_valid = r_res_valid;

endmodule

// File: tb/tb_sar_burst_avg.sv
// -----------------------------------------------------------------------------
// tb_sar_burst_avg
// Directed bench for sar_burst_avg at NBIT=10, LOG2_AVG=2, TIMEOUT=64.
// A simple SAR responder answers each soc after a chosen delay; expected
// averages and flags are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sar_burst_avg;
   import sar_pkg::*;

   logic       f100m_clk;
   logic       rstb;
   logic       start;
   logic       cont;
   logic       soc;
   logic       eoc;
   logic       err;
   logic       warn;
   logic [9:0] code;
   logic [9:0] res_data;
   logic       res_err;
   logic       res_warn;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic       timeout;

   int n_chk = 0;
   int n_err = 0;
   int n_soc = 0;
   int n_to  = 0;

   sar_burst_avg #(
      .NBIT     (10),
      .LOG2_AVG (2),
      .TIMEOUT  (64)
   ) dut (
      .f100m_clk (f100m_clk),
      .rstb      (rstb),
      .start     (start),
      .cont      (cont),
      .soc       (soc),
      .eoc       (eoc),
      .err       (err),
      .warn      (warn),
      .code      (code),
      .res_data  (res_data),
      .res_err   (res_err),
      .res_warn  (res_warn),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy),
      .timeout   (timeout)
   );

   initial f100m_clk = 1'b0;
   always #5 f100m_clk = ~f100m_clk;

   always @(posedge f100m_clk) begin
      if (soc === 1'b1)     n_soc++;
      if (timeout === 1'b1) n_to++;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic sar_res_t mk(input logic [9:0] d, input logic e, input logic w);
      sar_res_t r;
      r.data = d;
      r.err  = e;
      r.warn = w;
      return r;
   endfunction

   // Answer one soc: wait for it, then return eoc+code dly cycles later.
   task automatic do_conv(input logic [9:0] c, input int dly, input bit perr, input bit pwarn);
      int t = 0;
      while (soc !== 1'b1 && t < 300) begin
         @(negedge f100m_clk);
         t++;
      end
      if (soc !== 1'b1) chk("soc_wait", soc, 1);
      for (int i = 1; i <= dly; i++) begin
         @(negedge f100m_clk);
         err = perr && (i == dly / 2);
      end
      eoc  = 1'b1;
      code = c;
      warn = pwarn;
      @(negedge f100m_clk);
      eoc  = 1'b0;
      warn = 1'b0;
      err  = 1'b0;
   endtask

   // Run conversions skip..3, check the result, then hand it off. With
   // res_ready already high the result must last one cycle; otherwise it is
   // held for 'hold' cycles before ready is raised.
   task automatic burst(input string tag, input logic [9:0] c0, c1, c2, c3,
                        input int skip, input int dly, input int errc, input bit wlast,
                        input sar_res_t xr, input int hold);
      logic [9:0] cs [4];
      int bad;
      cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
      for (int i = skip; i < 4; i++) do_conv(cs[i], dly, errc == i, wlast && (i == 3));
      chk({tag, "_valid"}, res_valid, 1);
      chk({tag, "_data"},  res_data,  xr.data);
      chk({tag, "_err"},   res_err,   xr.err);
      chk({tag, "_warn"},  res_warn,  xr.warn);
      chk({tag, "_nosoc"}, soc,       0);
      if (res_ready) begin
         @(negedge f100m_clk);
         chk({tag, "_1cyc"}, res_valid, 0);
      end else begin
         bad = 0;
         for (int i = 0; i < hold; i++) begin
            @(negedge f100m_clk);
            if (res_valid !== 1'b1 || res_data !== xr.data || soc !== 1'b0) bad++;
         end
         if (hold > 0) chk({tag, "_hold"}, bad, 0);
         res_ready = 1'b1;
         @(negedge f100m_clk);
         res_ready = 1'b0;
         chk({tag, "_clr"}, res_valid, 0);
      end
   endtask

   task automatic go();
      @(negedge f100m_clk);
      start = 1'b1;
      @(negedge f100m_clk);
      start = 1'b0;
   endtask

   initial begin
      int s0, t0, early;
      rstb = 1'b0; start = 1'b0; cont = 1'b0; eoc = 1'b0;
      err = 1'b0; warn = 1'b0; code = '0; res_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge f100m_clk);
      chk("rst_soc",   soc,       0);
      chk("rst_valid", res_valid, 0);
      chk("rst_data",  res_data,  0);
      chk("rst_flags", {res_err, res_warn}, 0);
      chk("rst_busy",  busy,      0);
      chk("rst_to",    timeout,   0);
      rstb = 1'b1;

      // Spurious eoc/err/warn while idle
      @(negedge f100m_clk);
      eoc = 1'b1; err = 1'b1; warn = 1'b1; code = 10'd500;
      @(negedge f100m_clk);
      eoc = 1'b0; err = 1'b0; warn = 1'b0;
      chk("idle_eoc_busy", busy, 0);
      chk("idle_eoc_soc",  soc,  0);

      // Single burst
      s0 = n_soc;
      go();
      chk("start_soc", soc, 1);
      burst("b1", 10'd100, 10'd101, 10'd102, 10'd103, 0, 20, -1, 1'b0, mk(10'd101, 1'b0, 1'b0), 0);
      chk("b1_idle", busy, 0);
      repeat (10) @(negedge f100m_clk);
      chk("b1_soc_cnt", n_soc - s0, 4);

      // Full scale and truncation
      go();
      burst("fs", 10'd1023, 10'd1023, 10'd1023, 10'd1023, 0, 3, -1, 1'b0, mk(10'd1023, 1'b0, 1'b0), 0);
      res_ready = 1'b1;
      go();
      burst("tr", 10'd0, 10'd0, 10'd0, 10'd3, 0, 3, -1, 1'b0, mk(10'd0, 1'b0, 1'b0), 0);
      res_ready = 1'b0;
      chk("tr_idle", busy, 0);

      // Flags, then a clean burst
      go();
      burst("fl", 10'd10, 10'd20, 10'd30, 10'd40, 0, 20, 1, 1'b1, mk(10'd25, 1'b1, 1'b1), 0);
      go();
      burst("fl2", 10'd7, 10'd7, 10'd7, 10'd8, 0, 5, -1, 1'b0, mk(10'd7, 1'b0, 1'b0), 0);

      // Continuous mode with back-pressure
      @(negedge f100m_clk);
      cont = 1'b1;
      @(negedge f100m_clk);
      chk("cont_soc", soc, 1);
      burst("bp", 10'd200, 10'd201, 10'd202, 10'd203, 0, 4, -1, 1'b0, mk(10'd201, 1'b0, 1'b0), 50);
      chk("bp_next_soc", soc, 1);
      cont = 1'b0;
      burst("drop", 10'd5, 10'd6, 10'd7, 10'd8, 0, 4, -1, 1'b0, mk(10'd6, 1'b0, 1'b0), 0);
      chk("drop_idle", busy, 0);

      // Timeout with eoc withheld
      t0 = n_to;
      go();
      chk("to_soc", soc, 1);
      early = 0;
      repeat (63) begin
         @(negedge f100m_clk);
         if (timeout !== 1'b0) early++;
      end
      chk("to_early", early, 0);
      @(negedge f100m_clk);
      chk("to_pulse", timeout, 1);
      chk("to_busy_hi", busy, 1);
      @(negedge f100m_clk);
      chk("to_busy_lo", busy, 0);
      chk("to_pulse_end", timeout, 0);
      chk("to_novalid", res_valid, 0);
      chk("to_count", n_to - t0, 1);

      // eoc exactly in the expiry cycle wins
      go();
      repeat (64) @(negedge f100m_clk);
      eoc = 1'b1; code = 10'd40;
      #1;
      chk("exp_no_to", timeout, 0);
      @(negedge f100m_clk);
      eoc = 1'b0;
      chk("exp_next_soc", soc, 1);
      burst("exp", 10'd40, 10'd40, 10'd40, 10'd44, 1, 6, -1, 1'b0, mk(10'd41, 1'b0, 1'b0), 0);
      chk("exp_to_count", n_to - t0, 1);

      // Asynchronous reset during the third WAIT
      t0 = n_to;
      go();
      do_conv(10'd300, 8, 1'b0, 1'b0);
      do_conv(10'd300, 8, 1'b0, 1'b0);
      chk("rst3_soc", soc, 1);
      repeat (5) @(negedge f100m_clk);
      rstb = 1'b0;
      #1;
      chk("arst_busy",  busy,      0);
      chk("arst_soc",   soc,       0);
      chk("arst_valid", res_valid, 0);
      chk("arst_data",  res_data,  0);
      chk("arst_to",    timeout,   0);
      repeat (2) @(negedge f100m_clk);
      rstb = 1'b1;
      repeat (3) @(negedge f100m_clk);
      chk("arst_idle", busy, 0);
      chk("arst_no_to", n_to - t0, 0);
      go();
      burst("post", 10'd50, 10'd60, 10'd70, 10'd80, 0, 7, -1, 1'b0, mk(10'd65, 1'b0, 1'b0), 0);
      chk("post_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sar_burst_avg.md
# sar_burst_avg

Digital conversion sequencer sitting directly above the SAR controller's synchronised handshake on the f100m_clk domain. It issues start-of-conversion pulses toward the toggle resynchroniser and collects each resynchronised end-of-conversion with its code. It averages a burst of 2^LOG2_AVG conversions and presents the result on a valid/ready interface with error, warning and timeout status. It replaces the free-running "soc <= eoc" loop used today with controlled single-burst or continuous operation.

## Interface
- NBIT, 10: SAR code width.
- LOG2_AVG, 2: log2 of conversions per burst; legal range 0..6.
- TIMEOUT, 64: f100m_clk cycles allowed between soc and eoc; at least 2.

- f100m_clk  in  1  system clock, 100 MHz.
- rstb  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request for a single burst.
- cont  in  1  level; continuous burst mode while high.
- soc  out  1  one-cycle start-of-conversion pulse, goes to the toggle_resync_out input.
- eoc  in  1  one-cycle end-of-conversion pulse, already resynchronised.
- err  in  1  one-cycle SAR error pulse, already resynchronised.
- warn  in  1  one-cycle SAR warning pulse, already resynchronised.
- code  in  NBIT  SAR result; stable whenever eoc is high.
- res_data  out  NBIT  averaged result.
- res_err  out  1  an err pulse was seen during this burst.
- res_warn  out  1  a warn pulse was seen during this burst.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  state is not IDLE.
- timeout  out  1  one-cycle pulse when a burst is aborted.

## Operation
- Reset values: all outputs 0. State is IDLE; accumulator, sample count, watchdog and sticky flags are cleared.
- **IDLE**
  - Leaves on start=1 or cont=1, going to SOC.
  - eoc, err and warn are ignored here.
- **SOC**
  - soc=1 for exactly this cycle.
  - Watchdog is cleared.
  - Always goes to WAIT.
- **WAIT**
  - On eoc: acc <= acc + code, with acc width NBIT+LOG2_AVG and no overflow possible.
  - If count == 2^LOG2_AVG-1, go to OUT. Otherwise increment count and go to SOC.
  - If the watchdog reaches TIMEOUT-1 with no eoc: pulse timeout, clear acc/count/flags, go to IDLE. This applies even if cont=1.
  - If eoc and watchdog expiry occur in the same cycle, eoc wins.
- **err / warn capture**: in SOC or WAIT, each sets its sticky flag. A flag pulse in the same cycle as the final eoc is included in that result.
- **Result on entry to OUT**: res_data <= (acc + code) >> LOG2_AVG, truncated. res_err and res_warn take the sticky values. res_valid <= 1.
- **OUT**
  - Holds res_data, res_err, res_warn and res_valid stable until res_ready=1.
  - On the handshake: clear acc/count/flags and res_valid. Go to SOC if cont=1, otherwise IDLE.
  - No soc is issued while in OUT (back-pressure).
- start while busy is ignored.
- Dropping cont mid-burst lets the current burst finish, then the block returns to IDLE.
- eoc received while in SOC or OUT is spurious and is ignored.

## Timing
- Cycle numbering:
  - start sampled high at edge k gives soc=1 during cycle k+1.
  - eoc sampled at edge n gives either soc during cycle n+1 or res_valid during cycle n+1.
- Per-conversion overhead is 2 cycles plus the SAR latency.
- After the handshake at edge h with cont=1, the next soc is in cycle h+1.
- Watchdog counts the cycles spent in WAIT. With TIMEOUT=64, the timeout pulse falls in the 64th cycle after soc, and busy=0 on the following cycle.
- With res_ready tied high, res_valid lasts exactly one cycle.
- Asynchronous reset mid-burst: immediate return to the reset values; no result and no timeout pulse.

## Structure
- Shared package sar_pkg:
  - state enum (IDLE, SOC, WAIT, OUT)
  - default NBIT/LOG2_AVG/TIMEOUT constants
  - result struct {data, err, warn}
- One sub-module, sar_watchdog: a counter with clear and enable inputs and a terminal-count pulse output, parameterised by TIMEOUT.
- FSM, accumulator and output register live in the top module.

## Test plan
- **Single burst**: LOG2_AVG=2, start, codes 100/101/102/103 each returned 20 cycles after soc -> exactly 4 soc pulses, then res_data=101 with res_err=0 and res_warn=0, then IDLE.
- **Truncation and extreme**: codes 1023 x4 -> res_data=1023. Codes 0/0/0/3 -> res_data=0.
- **Back-pressure in continuous mode**: cont=1, res_ready low for 50 cycles -> no soc, res_valid and res_data held. After ready, the next soc arrives 1 cycle later.
- **Timeout**: soc issued, eoc withheld -> timeout pulse 64 cycles after soc, busy=0, no res_valid. Repeat with eoc arriving exactly in the expiry cycle -> no timeout, sample accepted.
- **Flags**: err pulse during the 2nd conversion and warn coincident with the final eoc -> res_err=1 and res_warn=1. The next burst reports both as 0.
- **Reset and spurious inputs**: rstb low during the 3rd WAIT -> all outputs 0 immediately, and a fresh start yields a correct 4-sample average. eoc pulses while IDLE -> no effect.
